// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: issues in-order imem requests under credit limits and pushes {pc, instr} to the fetch queue.
// Request is combinational from state/credits; push is registered one cycle after the response; stale responses are discarded after flushes.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_VEC       = 32'h80000000,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gc_fetch_hold,
    input  logic             gc_fetch_flush,
    input  logic             gc_fetch_pc_override,
    input  logic [31:0]      gc_fetch_pc,
    input  logic             branch_flush,
    input  logic [31:0]      branch_target,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rsp_data,
    input  logic [CNT_W-1:0] fq_free,
    output logic             fq_push,
    output logic [31:0]      fq_pc,
    output logic [31:0]      fq_instruction,
    output logic [CNT_W-1:0] outstanding
);

    localparam logic [1:0] RST_S    = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] REDIRECT = 2'd3;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [31:0]      pc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] out_dec;
    logic             flush;
    logic             accept;
    logic             rsp_keep;

    assign flush    = gc_fetch_flush | branch_flush | gc_fetch_pc_override;
    // Gating on every flush source keeps a flush cycle free of accepts.
    assign mem_req  = (state == RUN) & ~gc_fetch_hold & ~flush
                    & (outstanding < MAX_CNT) & (outstanding < fq_free);
    assign mem_addr = pc;
    assign accept   = mem_req & mem_ack;
    assign rsp_keep = mem_rsp_valid & ~flush & (discard == '0);
    // An illegal response with nothing in flight saturates at zero.
    assign out_dec  = (mem_rsp_valid && outstanding != '0) ? outstanding - 1'b1 : outstanding;

    always_comb begin
        state_nxt = state;
        case (state)
            RST_S:    state_nxt = RUN;
            RUN:      state_nxt = gc_fetch_pc_override ? REDIRECT : (gc_fetch_hold ? HELD : RUN);
            HELD:     state_nxt = gc_fetch_pc_override ? REDIRECT : (gc_fetch_hold ? HELD : RUN);
            REDIRECT: state_nxt = gc_fetch_pc_override ? REDIRECT : RUN;
            default:  state_nxt = RST_S;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RST_S;
            pc             <= RESET_VEC;
            rsp_pc         <= RESET_VEC;
            outstanding    <= '0;
            discard        <= '0;
            fq_push        <= 1'b0;
            fq_pc          <= '0;
            fq_instruction <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_dec + CNT_W'(accept);
            fq_push     <= rsp_keep;

            if (gc_fetch_pc_override) begin
                pc     <= gc_fetch_pc;
                rsp_pc <= gc_fetch_pc;
            end else if (branch_flush) begin
                pc     <= branch_target;
                rsp_pc <= branch_target;
            end else begin
                if (accept)
                    pc <= pc + 32'd4;
                if (rsp_keep)
                    rsp_pc <= rsp_pc + 32'd4;
            end

            // Everything still in flight after this cycle belongs to the old stream.
            if (flush)
                discard <= out_dec;
            else if (mem_rsp_valid && discard != '0)
                discard <= discard - 1'b1;

            if (rsp_keep) begin
                fq_pc          <= rsp_pc;
                fq_instruction <= mem_rsp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_rsp_valid)
            assert (outstanding != '0);
    end

endmodule
